clk_div_multi: RTL

- Multi-channel, fully synchronous programmable clock generator; next generation of the prescaler plus gated-divider block.
- One shared power-of-two prescaler feeds P_CH independent channels. Each channel has its own divide ratio, duty cycle and enable.
- All outputs are registered in the clk domain, with no ripple clocks and no latches.
- Reconfiguration uses a valid/ready port with per-channel shadow registers. Changes commit only at a period boundary, so outputs are glitch-free.

---
 rtl/clk_div_multi_pkg.sv | 26 ++
 rtl/clk_div_chan.sv | 85 ++++++++
 rtl/clk_div_multi.sv | 71 +++++++
 3 files changed

// File: rtl/clk_div_multi_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Config fields are carried at their widest supported width; narrower
// top-level ports are zero-extended into this struct.
package clk_div_multi_pkg;

  localparam int P_CH_DEF        = 2;
  localparam int P_PSEL_BITS_DEF = 3;
  localparam int P_CNT_BITS_DEF  = 8;

  // Widest supported field widths (P_PSEL_BITS <= 4, P_CNT_BITS <= 16).
  localparam int PSEL_W_MAX = 4;
  localparam int CNT_W_MAX  = 16;

  typedef struct packed {
    logic [PSEL_W_MAX-1:0] pre_sel;
    logic [CNT_W_MAX-1:0]  div;
    logic [CNT_W_MAX-1:0]  high;
    logic                  en;
  } ch_cfg_t;

  // Channel-select width: ceil(log2(n)), never less than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active/shadow config, period counter, pending flag
// and registered clk_out / period_tick. Taps the shared prescaler count.
module clk_div_chan
  import clk_div_multi_pkg::*;
#(
  parameter int PRE_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PRE_W-1:0] pre_cnt_i,
  input  logic             wr_i,
  input  ch_cfg_t          wr_cfg_i,
  output logic             clk_out_o,
  output logic             period_tick_o,
  output logic             cfg_pending_o
);

  localparam int PW1 = PRE_W + 1;

  ch_cfg_t              act_q, act_d;
  ch_cfg_t              shd_q, shd_d;
  logic                 pend_q, pend_d;
  logic [CNT_W_MAX-1:0] cnt_q, cnt_d;
  logic                 out_q, out_d;
  logic                 tick_q, tick_d;

  logic [PW1-1:0]       one_sh;
  logic [PRE_W-1:0]     mask;
  logic                 ptick;
  logic                 boundary;
  logic                 commit;
  ch_cfg_t              nxt;
  logic [CNT_W_MAX-1:0] nxt_cnt;

  // Tick decode, boundary/commit detection and next-state for all registers.
  always_comb begin
    one_sh   = PW1'(1) << act_q.pre_sel;
    mask     = PRE_W'(one_sh - PW1'(1));
    ptick    = (pre_cnt_i & mask) == mask;
    boundary = act_q.en & ptick & (cnt_q == act_q.div);
    // A disabled channel has no period to finish, so its shadow lands at once.
    commit   = pend_q & (boundary | ~act_q.en);
    nxt      = commit ? shd_q : act_q;
    nxt_cnt  = (boundary | commit) ? '0 : cnt_q + CNT_W_MAX'(1);

    act_d  = nxt;
    shd_d  = wr_i ? wr_cfg_i : shd_q;
    // wr_i is only possible while pend_q is clear, so it never races commit.
    pend_d = wr_i | (pend_q & ~commit);
    cnt_d  = cnt_q;
    out_d  = out_q;
    tick_d = 1'b0;
    // Registers move on a prescale tick of a running channel, or on a commit
    // (which also starts slot 0 of a freshly enabled channel immediately).
    if (commit | (act_q.en & ptick)) begin
      cnt_d  = nxt.en ? nxt_cnt : '0;
      out_d  = nxt.en & (nxt_cnt < nxt.high);
      tick_d = (commit | boundary) & nxt.en;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q  <= '0;
      shd_q  <= '0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out_o     = out_q;
  assign period_tick_o = tick_q;
  assign cfg_pending_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock generator: shared free-running
// power-of-two prescaler, per-channel dividers with shadowed config that
// commits only at period boundaries.
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter  int P_CH        = P_CH_DEF,
  parameter  int P_PSEL_BITS = P_PSEL_BITS_DEF,
  parameter  int P_CNT_BITS  = P_CNT_BITS_DEF,
  localparam int CH_W        = ch_w(P_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [P_PSEL_BITS-1:0] cfg_pre_sel,
  input  logic [P_CNT_BITS-1:0]  cfg_div,
  input  logic [P_CNT_BITS-1:0]  cfg_high,
  input  logic                   cfg_en,
  output logic [P_CH-1:0]        clk_out,
  output logic [P_CH-1:0]        period_tick,
  output logic [P_CH-1:0]        cfg_pending
);

  localparam int PRE_W = (1 << P_PSEL_BITS) - 1;
  localparam int CH_N  = 1 << CH_W;

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CH_N-1:0]  pend_pad;
  logic             acc;
  logic [P_CH-1:0]  wr;
  ch_cfg_t          wr_cfg;

  // Prescaler just wraps; every channel taps its own low-bit window.
  always_comb pre_cnt_d = pre_cnt_q + PRE_W'(1);

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_cnt_q <= '0;
    else       pre_cnt_q <= pre_cnt_d;
  end

  // Ready mux and channel decode; out-of-range channels read as never
  // pending, so such writes are accepted and dropped.
  always_comb begin
    pend_pad       = CH_N'(cfg_pending);
    cfg_ready      = ~pend_pad[cfg_ch];
    acc            = cfg_valid & cfg_ready;
    wr_cfg.pre_sel = PSEL_W_MAX'(cfg_pre_sel);
    wr_cfg.div     = CNT_W_MAX'(cfg_div);
    wr_cfg.high    = CNT_W_MAX'(cfg_high);
    wr_cfg.en      = cfg_en;
    wr             = '0;
    for (int c = 0; c < P_CH; c++) wr[c] = acc & (cfg_ch == CH_W'(c));
  end

  for (genvar g = 0; g < P_CH; g++) begin : g_ch
    clk_div_chan #(.PRE_W(PRE_W)) u_chan (
      .clk          (clk),
      .reset        (reset),
      .pre_cnt_i    (pre_cnt_q),
      .wr_i         (wr[g]),
      .wr_cfg_i     (wr_cfg),
      .clk_out_o    (clk_out[g]),
      .period_tick_o(period_tick[g]),
      .cfg_pending_o(cfg_pending[g])
    );
  end

endmodule
